// File: rtl/alu_exec_stage_pkg.sv
// Shared types and constants for the registered ALU execute stage.
// ALUop encodings, datapath widths and the inter-stage bundles.
package alu_exec_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] dst;
  } id_ex_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  ovf;
    logic                  cout;
    logic                  zero;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] dst;
  } ex_wb_t;

  localparam int ENTRY_W = $bits(ex_wb_t);

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, SLT.
// SUB/SLT carry-out reports an unsigned borrow (a < b).
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_W-1:0]       op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf,
  output logic                  cout,
  output logic                  zero,
  output logic                  illegal
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                add_ovf;
  logic                sub_ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign add_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                   (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  assign sub_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                   (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    cout    = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_AND): result = a & b;
      (op == OP_OR):  result = a | b;
      (op == OP_ADD): begin
        result = sum[DATA_WIDTH-1:0];
        ovf    = add_ovf;
        cout   = sum[DATA_WIDTH];
      end
      (op == OP_SUB): begin
        result = diff[DATA_WIDTH-1:0];
        ovf    = sub_ovf;
        cout   = diff[DATA_WIDTH];
      end
      (op == OP_SLT): begin
        // signed compare must correct the sign bit on overflow
        result = {{(DATA_WIDTH-1){1'b0}},
                  diff[DATA_WIDTH-1] ^ sub_ovf};
        ovf    = sub_ovf;
        cout   = diff[DATA_WIDTH];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: S1 operand register, ALU, 2-entry output buffer.
// Define ALU_EXEC_STICKY_OVF_EN to build the sticky overflow register.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]       in_op,
  input  logic [REG_ADDR_W-1:0] in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_ovf,
  output logic                  out_cout,
  output logic                  out_zero,
  output logic                  out_illegal,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  ovf_sticky,
  input  logic                  ovf_clear
);

  id_ex_t      s1;
  logic        s1_valid;
  ex_wb_t      alu_entry;
  ex_wb_t      buf_q [2];
  ex_wb_t      head;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        accept;
  logic        s1_move;
  logic        pop;

  alu_exec_stage_alu u_alu (
    .a       (s1.a),
    .b       (s1.b),
    .op      (s1.op),
    .result  (alu_entry.result),
    .ovf     (alu_entry.ovf),
    .cout    (alu_entry.cout),
    .zero    (alu_entry.zero),
    .illegal (alu_entry.illegal)
  );

  assign alu_entry.dst = s1.dst;

  // ready depends on registered state only
  assign in_ready  = ~s1_valid | (cnt != 2'd2);
  assign accept    = in_valid & in_ready;
  assign s1_move   = s1_valid & (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1       <= '{a: in_a, b: in_b, op: in_op, dst: in_dst};
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      if (s1_move) begin
        buf_q[wr_ptr] <= alu_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({s1_move, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head        = buf_q[rd_ptr];
  assign out_result  = head.result;
  assign out_ovf     = head.ovf;
  assign out_cout    = head.cout;
  assign out_zero    = head.zero;
  assign out_illegal = head.illegal;
  assign out_dst     = head.dst;

`ifdef ALU_EXEC_STICKY_OVF_EN
  logic sticky_q;

  // a fresh overflow push wins over a concurrent clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sticky_q <= 1'b0;
    end else if (s1_move && alu_entry.ovf) begin
      sticky_q <= 1'b1;
    end else if (ovf_clear) begin
      sticky_q <= 1'b0;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_clear;

  assign unused_clear = ovf_clear;
  assign ovf_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed cases plus random traffic.
// Expected bundles come from an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [4:0]  in_dst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_cout;
  logic        out_zero;
  logic        out_illegal;
  logic [4:0]  out_dst;
  logic        ovf_sticky;
  logic        ovf_clear;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_dst      (in_dst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_cout    (out_cout),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .out_dst     (out_dst),
    .ovf_sticky  (ovf_sticky),
    .ovf_clear   (ovf_clear)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        cout;
    logic        zero;
    logic        ill;
    logic [4:0]  dst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_on;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit out_of_range(input longint r);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [4:0] dst);
    exp_t   e;
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    e = '{res: 32'h0, ovf: 1'b0, cout: 1'b0, zero: 1'b0, ill: 1'b0, dst: dst};
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        u      = ua + ub;
        e.res  = u[31:0];
        e.cout = (u > 64'sd4294967295);
        e.ovf  = out_of_range(sa + sb);
      end
      3'd6: begin
        e.res  = a - b;
        e.cout = (ua < ub);
        e.ovf  = out_of_range(sa - sb);
      end
      3'd7: begin
        e.res  = (sa < sb) ? 32'd1 : 32'd0;
        e.cout = (ua < ub);
        e.ovf  = out_of_range(sa - sb);
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // monitor: pop and compare on every transfer, check hold stability
  logic        hold = 1'b0;
  logic [42:0] held;

  always @(negedge clk) begin
    exp_t e;
    logic [42:0] cur;
    cur = {out_result, out_ovf, out_cout, out_zero, out_illegal, out_dst};
    if (!resetn) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {20'b0, out_valid, cur}, {20'b0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {59'b0, out_dst}, 64'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("payload", {21'b0, cur},
              {21'b0, e.res, e.ovf, e.cout, e.zero, e.ill, e.dst});
        end
      end
      hold = out_valid & ~out_ready;
      held = cur;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] dst);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_dst   = dst;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, op, dst));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_dst    = '0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_sticky", {63'b0, ovf_sticky}, 64'd0);
    chk("rst_payload", {27'b0, out_result, out_dst}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();

    // ADD overflow, latency one cycle after accept
    out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 5'd5);
    @(negedge clk);
    chk("lat_edge_k", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_edge_k1", {58'b0, out_valid, out_dst}, {58'b0, 1'b1, 5'd5});
    drain();

    // SUB then SLT back to back
    send(32'd5, 32'd5, 3'b110, 5'd6);
    send(32'hFFFFFFFF, 32'h00000001, 3'b111, 5'd7);
    @(negedge clk);
    chk("b2b_first", {58'b0, out_valid, out_dst}, {58'b0, 1'b1, 5'd6});
    @(negedge clk);
    chk("b2b_second", {58'b0, out_valid, out_dst}, {58'b0, 1'b1, 5'd7});
    drain();

    // illegal opcode flows through
    send(32'h0000FFFF, 32'h00000001, 3'b011, 5'd8);
    drain();

    // capacity three with out_ready low, then in-order gapless release
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(32'(i), 32'd1, 3'b010, 5'(i));
    in_valid = 1'b1;
    in_dst   = 5'd4;
    @(negedge clk);
    chk("cap_full_ready", {63'b0, in_ready}, 64'd0);
    tick();
    out_ready = 1'b1;
    fork
      send(32'd4, 32'd1, 3'b010, 5'd4);
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        chk("release_nogap", {58'b0, out_valid, out_dst}, {58'b0, 1'b1, 5'(i)});
      end
    join
    drain();

    // asynchronous reset with buffer full and S1 occupied
    out_ready = 1'b0;
    for (int i = 10; i < 13; i++) send(32'(i), 32'd3, 3'b001, 5'(i));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_in_ready", {63'b0, in_ready}, 64'd1);
    chk("async_payload", {27'b0, out_result, out_dst}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();
    drain();

`ifdef ALU_EXEC_STICKY_OVF_EN
    send(32'h7FFFFFFF, 32'h1, 3'b010, 5'd1);
    tick();
    chk("sticky_set", {63'b0, ovf_sticky}, 64'd1);
    send(32'h3, 32'h1, 3'b000, 5'd2);
    drain();
    chk("sticky_persist", {63'b0, ovf_sticky}, 64'd1);
    send(32'h80000000, 32'h1, 3'b110, 5'd3);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("sticky_set_wins", {63'b0, ovf_sticky}, 64'd1);
    drain();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("sticky_clear", {63'b0, ovf_sticky}, 64'd0);
`else
    send(32'h7FFFFFFF, 32'h1, 3'b010, 5'd1);
    drain();
    chk("sticky_tied_off", {63'b0, ovf_sticky}, 64'd0);
`endif

    // random traffic with random back-pressure
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        tick();
        out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          repeat ($urandom_range(0, 2)) tick();
          case ($urandom_range(0, 3))
            0: ra = 32'h7FFFFFFF;
            1: ra = 32'h80000000;
            2: ra = $urandom_range(0, 7);
            default: ra = $urandom;
          endcase
          rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          send(ra, rb, 3'($urandom_range(0, 7)), 5'($urandom));
        end
        rnd_on = 1'b0;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapping the combinational 32-bit ALU. Accepts operand/opcode/destination bundles from decode over a valid/ready handshake, holds them in one operand register, evaluates them through the ALU, and queues result plus flags in a 2-entry output buffer toward writeback. Provides the datapath's first back-pressurable execute boundary.

## Interface
- DATA_WIDTH, 32, operand/result width (fixed 32 for this ALU)
- REG_ADDR_W, 5, destination register index width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  decode offers a bundle
- in_ready  out  1  stage accepts bundle this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_op  in  3  ALUop: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
- in_dst  in  5  destination register index, passed through
- out_valid  out  1  head of output buffer valid
- out_ready  in  1  writeback consumes head
- out_result  out  32  ALU Result
- out_ovf, out_cout, out_zero  out  1 each  ALU Overflow/CarryOut/Zero
- out_illegal  out  1  in_op was an illegal code
- out_dst  out  5  passed-through destination
- ovf_sticky  out  1  sticky overflow (see Configuration)
- ovf_clear  in  1  clears ovf_sticky

## Operation
- S1 operand register: s1_valid, a, b, op, dst. Load on in_valid & in_ready.
- ALU sub-module combinationally evaluates S1 contents; flags exactly as ALU defines (ovf/cout forced 0 for AND/OR/illegal; result 0 for illegal).
- s1_move = s1_valid & (cnt != 2). On s1_move, push {result, flags, illegal, dst} into output buffer; S1 empties unless reloaded same cycle.
- in_ready = ~s1_valid | (cnt != 2); registered signals only, no out_ready→in_ready path.
- Output buffer: 2 entries, circular, 1-bit wr/rd pointers, 2-bit cnt (0..2). pop = out_valid & out_ready. out_* = head entry; out_valid = cnt != 0.
- Push+pop same cycle: cnt unchanged, order preserved. Push never occurs at cnt==2.
- Illegal ops {011,100,101} flow normally: result 0, zero 1, illegal 1.
- Strict in-order; no bundle dropped or duplicated.

## Timing
- Reset (async assert, sync-release assumed by top): s1_valid 0, cnt 0, pointers 0, out_valid 0, ovf_sticky 0, out payload 0; in_ready 1.
- Latency: accepted at edge k → out_valid after edge k+1 (buffer not full).
- Throughput: 1 bundle/cycle while out_ready held high.
- out_ready low: capacity 3 bundles (2 buffer + S1); 4th sees in_ready 0.
- out_valid/payload stable while out_valid & ~out_ready.
- resetn asserted mid-operation: all in-flight bundles discarded immediately, outputs go to reset values without waiting for clk.

## Configuration
- ALU_EXEC_STICKY_OVF_EN defined: ovf_sticky sets on the cycle a bundle with ovf=1 is pushed into the output buffer; clears on ovf_clear; set wins over clear same cycle.
- Undefined: ovf_sticky tied 0, ovf_clear ignored, no register.

## Structure
- Shared package: ALUop codes (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), DATA_WIDTH, REG_ADDR_W, output-entry field widths.
- One sub-module: existing alu, instantiated once on S1 operands. Buffer inline.

## Test plan
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 → one cycle after accept: result 0x80000000, ovf 1, cout 0, zero 0.
- SUB 5−5 then SLT 0xFFFFFFFF vs 0x00000001, back-to-back → results 0x0 (zero 1, cout 0) then 0x1, consecutive cycles.
- out_ready=0, offer 4 bundles dst 1..4 → 3 accepted, in_ready 0 on 4th; release → dst 1,2,3,4 in order, no gaps after refill.
- in_op=011, A=0xFFFF, B=0x1 → result 0, zero 1, illegal 1, ovf 0, cout 0.
- Buffer full + S1 valid, resetn low between edges → out_valid 0, in_ready 1 immediately; after release no stale bundle emerges.
- With ALU_EXEC_STICKY_OVF_EN: overflowing ADD → ovf_sticky 1 persists over clean ops; ovf_clear with concurrent overflow push → stays 1; lone ovf_clear → 0.
